store_unit: RTL
===============

STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 SHALL have parameter n, default 32, meaning CPU/memory data and address width.
REQ-002 SHALL have parameter DEPTH, default 2, meaning store-buffer entries.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port st_valid  input  1  CPU store request valid.
REQ-006 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-007 SHALL have port st_addr  input  n  byte address of store.
REQ-008 SHALL have port st_data  input  n  store data, LSB-justified.
REQ-009 SHALL have port st_size  input  2  00=SB, 01=SH, 10=SW, 11=illegal.
REQ-010 SHALL have port mem_req  output  1  data-memory write request.
REQ-011 SHALL have port mem_ack  input  1  memory accepts current write.
REQ-012 SHALL have port mem_addr  output  n  word-aligned write address, bits [1:0]=00.
REQ-013 SHALL have port mem_wdata  output  n  lane-aligned write data.
REQ-014 SHALL have port mem_be  output  4  byte-lane enables, bit i = bits [8i+7:8i].
REQ-015 SHALL have port busy  output  1  buffer non-empty or transaction in flight.
REQ-016 SHALL have port err  output  1  one-cycle pulse on illegal st_size.

Function
REQ-017 SHALL accept a store when st_valid and st_ready are both high on a rising edge.
REQ-018 SHALL drive st_ready = (buffer occupancy < DEPTH), from registered occupancy only; a same-cycle pop SHALL NOT raise st_ready.
REQ-019 SHALL, on accepting st_size=11, not enqueue the store and pulse err high for exactly the following cycle.
REQ-020 SHALL store entries in a FIFO (circular pointers, wrap at DEPTH) and issue them to memory in acceptance order.
REQ-021 SHALL compute lane mask M = 0001/0011/1111 for SB/SH/SW, shifted left by a=st_addr[1:0] into a 7-bit mask; low 4 bits form beat 0, high 3 bits form beat 1.
REQ-022 SHALL shift data left by 8*a for beat 0; beat 1 data = data >> 8*(4-a), placed from lane 0; disabled lanes SHALL be driven 0.
REQ-023 SHALL use FSM states IDLE, BEAT0, BEAT1: IDLE->BEAT0 when buffer non-empty; BEAT0->BEAT1 on mem_ack if beat-1 mask non-zero, else ->IDLE and pop; BEAT1->IDLE on mem_ack and pop.
REQ-024 SHALL assert mem_req only in BEAT0/BEAT1 and hold mem_req, mem_addr, mem_wdata, mem_be stable until the cycle mem_ack is high.
REQ-025 SHALL use mem_addr = {st_addr[n-1:2],00} in BEAT0 and that value + 4 in BEAT1 (wrapping modulo 2^n at top of address space).
REQ-026 SHALL ignore mem_ack while mem_req is low.
REQ-027 SHALL, for an entry accepted into an empty buffer in IDLE at edge N, raise mem_req from cycle N+1; after BEAT0 completes with no beat 1, the next queued entry SHALL be requested from the second cycle after the completing mem_ack.
REQ-028 SHALL, when push and pop coincide with a non-full buffer, keep occupancy unchanged.
REQ-029 SHALL drive busy = (occupancy != 0) or (state != IDLE).

Reset
REQ-030 SHALL, on rst high at a rising edge, set state IDLE, occupancy 0, pointers 0, mem_req 0, mem_be 0000, mem_addr 0, mem_wdata 0, err 0, busy 0; st_ready SHALL be 1 in the cycle after reset.
REQ-031 SHALL abandon any in-flight transaction and discard buffered stores on reset, even mid-BEAT0/BEAT1; rst SHALL take priority over mem_ack and st_valid.

Verification
REQ-032 SW addr 0x100 data 0xDEADBEEF, mem_ack same cycle as first mem_req -> one beat: addr 0x100, be 1111, wdata 0xDEADBEEF, busy low after.
REQ-033 SB addr 0x203 data 0x000000A5 -> addr 0x200, be 1000, wdata 0xA5000000.
REQ-034 SW addr 0x102 data 0x11223344 -> beat 0: addr 0x100, be 1100, wdata 0x33440000; beat 1: addr 0x104, be 0011, wdata 0x00001122.
REQ-035 mem_ack held low, three back-to-back SW pushes -> first two accepted, st_ready low on third, mem_req outputs stable; release mem_ack -> stores emerge in order.
REQ-036 st_size=11 accepted -> err high exactly one cycle, no mem_req, occupancy unchanged.
REQ-037 rst during BEAT1 of misaligned SH with one entry queued -> next cycle mem_req 0, busy 0, st_ready 1; no further memory writes.

Source files
------------

// File: rtl/store_unit.sv
// Store buffer between the CPU store port and a 32-bit data memory.
// Queues stores in a small FIFO and splits misaligned stores into one or two lane-aligned write beats.
module store_unit #(
  parameter int n     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         st_valid,
  output logic         st_ready,
  input  logic [n-1:0] st_addr,
  input  logic [n-1:0] st_data,
  input  logic [1:0]   st_size,
  output logic         mem_req,
  input  logic         mem_ack,
  output logic [n-1:0] mem_addr,
  output logic [n-1:0] mem_wdata,
  output logic [3:0]   mem_be,
  output logic         busy,
  output logic         err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [n-1:0]   r_addr_q [DEPTH];
  logic [n-1:0]   r_data_q [DEPTH];
  logic [1:0]     r_size_q [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_err;

  logic           w_accept;
  logic           w_push;
  logic           w_pop;
  logic [n-1:0]   w_head_addr;
  logic [n-1:0]   w_head_data;
  logic [1:0]     w_head_size;
  logic [3:0]     w_lane_m;
  logic [6:0]     w_mask7;
  logic [3:0]     w_be0;
  logic [3:0]     w_be1;
  logic [4:0]     w_shift_lo;
  logic [n-1:0]   w_data0;
  logic [n-1:0]   w_data1;
  logic [n-1:0]   w_lane_mask0;
  logic [n-1:0]   w_lane_mask1;
  logic [n-1:0]   w_word_addr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign st_ready = (r_count < CW'(DEPTH));
  assign w_accept = st_valid && st_ready;
  assign w_push   = w_accept && (st_size != 2'b11);
  assign busy     = (r_count != '0) || (r_state != IDLE);
  assign err      = r_err;

  // NOTE: the entry storage has no reset; an entry is only ever read after it was written,
  // and every memory output is forced to zero outside BEAT0/BEAT1.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_wr_ptr] <= st_addr;
      r_data_q[r_wr_ptr] <= st_data;
      r_size_q[r_wr_ptr] <= st_size;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_err   <= w_accept && (st_size == 2'b11);
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head_addr = r_addr_q[r_rd_ptr];
  assign w_head_data = r_data_q[r_rd_ptr];
  assign w_head_size = r_size_q[r_rd_ptr];

  // The 7-bit lane mask spans two words: bits [3:0] land in the head word, bits [6:4] in the next.
  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_lane_m = 4'b0000;
    case (w_head_size)
      2'b00:   w_lane_m = 4'b0001;
      2'b01:   w_lane_m = 4'b0011;
      2'b10:   w_lane_m = 4'b1111;
      default: w_lane_m = 4'b0000;
    endcase
    w_mask7      = {3'b000, w_lane_m} << w_head_addr[1:0];
    w_be0        = w_mask7[3:0];
    w_be1        = {1'b0, w_mask7[6:4]};
    w_shift_lo   = {w_head_addr[1:0], 3'b000};
    w_data0      = w_head_data << w_shift_lo;
    w_data1      = w_head_data >> (6'd32 - {1'b0, w_shift_lo});
    w_word_addr  = {w_head_addr[n-1:2], 2'b00};
    w_lane_mask0 = '0;
    w_lane_mask1 = '0;
    for (int i = 0; i < 4; i++) begin
      w_lane_mask0[8*i +: 8] = {8{w_be0[i]}};
      w_lane_mask1[8*i +: 8] = {8{w_be1[i]}};
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    mem_req      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_be       = 4'b0000;
    case (r_state)
      IDLE: begin
        if (r_count != '0) w_next_state = BEAT0;
      end
      BEAT0: begin
        mem_req   = 1'b1;
        mem_addr  = w_word_addr;
        mem_wdata = w_data0 & w_lane_mask0;
        mem_be    = w_be0;
        if (mem_ack) begin
          if (w_be1 != 4'b0000) begin
            w_next_state = BEAT1;
          end else begin
            w_next_state = IDLE;
            w_pop        = 1'b1;
          end
        end
      end
      BEAT1: begin
        mem_req   = 1'b1;
        mem_addr  = w_word_addr + n'(4);
        mem_wdata = w_data1 & w_lane_mask1;
        mem_be    = w_be1;
        if (mem_ack) begin
          w_next_state = IDLE;
          w_pop        = 1'b1;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule
